// File: rtl/rvseed_fetch_pkg.sv
// -----------------------------------------------------------------------------
// rvseed_fetch_pkg
// Shared constants for the rvseed instruction-fetch stage.
//   CPU_WIDTH        : native datapath / address width of the core.
//   DEF_INST_WIDTH   : default instruction width.
//   DEF_FETCH_DEPTH  : default fetch buffer depth (also the fetch credit limit).
//   PC_STEP          : PC increment between sequential fetches.
//   PC_ALIGN_BITS    : low PC bits that must be zero for an aligned fetch.
// -----------------------------------------------------------------------------
package rvseed_fetch_pkg;

  localparam int CPU_WIDTH       = 32;
  localparam int DEF_INST_WIDTH  = 32;
  localparam int DEF_FETCH_DEPTH = 4;
  localparam int PC_STEP         = 4;
  localparam int PC_ALIGN_BITS   = 2;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rvseed_fetch_fifo.sv
// -----------------------------------------------------------------------------
// rvseed_fetch_fifo
// Generic synchronous FIFO with flush. The head entry is presented directly
// from the storage registers (no write-to-read bypass), so data pushed in a
// cycle becomes visible at the head one cycle later.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (pointers and count only)
//   flush      in   empty the FIFO at this edge; push/pop are ignored
//   push       in   write push_data (ignored when full)
//   push_data  in   WIDTH-bit entry to write
//   pop        in   discard head entry (ignored when empty)
//   head_data  out  WIDTH-bit entry at the head
//   count      out  number of valid entries, 0..DEPTH
//   empty      out  count == 0
// -----------------------------------------------------------------------------
module rvseed_fetch_fifo
  import rvseed_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_data,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg,  count_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !flush && (count_reg != CW'(DEPTH));
  assign pop_ok  = pop  && !flush && (count_reg != '0);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_ok) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: an entry is only observed after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign empty     = (count_reg == '0);

endmodule

// File: rtl/rvseed_fetch.sv
// -----------------------------------------------------------------------------
// rvseed_fetch
// Instruction-fetch stage: owns the fetch PC, issues requests to instruction
// memory over a valid/ready channel, collects in-order responses into a
// DEPTH-entry buffer tagged with their PCs and presents them to decode.
// Redirects from execute flush the buffer and discard in-flight responses.
//
// Optional feature (macro FETCH_MISALIGN_CHK_EN):
//   defined   - a redirect to a target with nonzero low bits sets the sticky
//               fetch_misalign flag and halts fetch until the next aligned
//               redirect.
//   undefined - the low target bits are ignored and fetch_misalign is 0.
//
// Ports:
//   clk             in   core clock
//   rst_n           in   asynchronous active-low reset
//   redirect_valid  in   branch/jump taken: flush and refetch
//   redirect_pc     in   redirect target
//   imem_req_valid  out  fetch request
//   imem_req_ready  in   memory accepts request
//   imem_req_addr   out  fetch address
//   imem_rsp_valid  in   one in-order response per accepted request
//   imem_rsp_inst   in   returned instruction
//   inst_valid      out  instruction available to decode
//   inst_ready      in   decode accepts
//   inst            out  instruction
//   inst_pc         out  PC of inst
//   fetch_misalign  out  misaligned-redirect flag
// -----------------------------------------------------------------------------
module rvseed_fetch
  import rvseed_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = CPU_WIDTH,
  parameter int                    INST_WIDTH = DEF_INST_WIDTH,
  parameter int                    DEPTH      = DEF_FETCH_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_inst,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  fetch_misalign
);

  localparam int CW = cnt_width(DEPTH);
  localparam int EW = ADDR_WIDTH + INST_WIDTH;

  logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  // PC that belongs to the next response that will be kept. Responses are in
  // order and stale ones are dropped, so this is just a running counter.
  logic [ADDR_WIDTH-1:0] rsp_pc_reg,   rsp_pc_next;
  logic [CW-1:0]         inflight_reg, inflight_next;
  logic [CW-1:0]         drop_cnt_reg, drop_cnt_next;

  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [EW-1:0]         fifo_head;
  logic                  credit_ok;
  logic                  fetch_halt;
  logic                  req_fire;
  logic                  keep_rsp;
  logic                  pop_req;

  // Fetch addresses are always word aligned; the low bits only matter for the
  // misalignment check.
  assign redirect_target = {redirect_pc[ADDR_WIDTH-1:PC_ALIGN_BITS], {PC_ALIGN_BITS{1'b0}}};

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_reg, misalign_next;

  always_comb begin
    misalign_next = misalign_reg;
    if (redirect_valid) misalign_next = |redirect_pc[PC_ALIGN_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_reg <= 1'b0;
    else        misalign_reg <= misalign_next;
  end

  assign fetch_halt     = misalign_reg;
  assign fetch_misalign = misalign_reg;
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[PC_ALIGN_BITS-1:0];
  assign fetch_halt          = 1'b0;
  assign fetch_misalign      = 1'b0;
`endif

  // Never have more requests outstanding than free buffer slots, so every
  // response is guaranteed a place in the FIFO.
  assign credit_ok = ({1'b0, inflight_reg} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);

  // rst_n gating keeps the request quiet while reset is held.
  assign imem_req_valid = rst_n && !redirect_valid && credit_ok && !fetch_halt;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response coincident with a redirect is stale as well.
  assign keep_rsp   = imem_rsp_valid && !redirect_valid && (drop_cnt_reg == '0);
  assign inst_valid = !fifo_empty && !redirect_valid;
  assign pop_req    = inst_valid && inst_ready;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rsp_pc_next   = rsp_pc_reg;
    inflight_next = inflight_reg + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_next = drop_cnt_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_target;
      rsp_pc_next   = redirect_target;
      // Everything still outstanding after this edge is stale.
      drop_cnt_next = inflight_reg - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(PC_STEP);
      if (keep_rsp) rsp_pc_next   = rsp_pc_reg + ADDR_WIDTH'(PC_STEP);
      if (imem_rsp_valid && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      rsp_pc_reg   <= rsp_pc_next;
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  rvseed_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (keep_rsp),
    .push_data ({rsp_pc_reg, imem_rsp_inst}),
    .pop       (pop_req),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign inst_pc = fifo_head[EW-1:INST_WIDTH];
  assign inst    = fifo_head[INST_WIDTH-1:0];

endmodule
